// File: rtl/memory_stage_if.sv
// Request/response bundle between execute, the memory stage and write-back.
// The master side issues a request; the slave side (memory_stage) answers it.
interface memory_stage_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic [2:0]  stat_in;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic [2:0]  stat;

  modport master (
    output start, icode, valA, valE, valP, stat_in,
    input  busy, done, valM, stat
  );

  modport slave (
    input  start, icode, valA, valE, valP, stat_in,
    output busy, done, valM, stat
  );
endinterface

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: one byte-serial 8-byte little-endian access per
// request into an internal byte-wide RAM, returning valM and updated status.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  memory_stage_if.slave bus
);
  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;

  logic [1:0]  stateReg;
  logic [2:0]  cntReg;
  logic [63:0] addrReg;
  logic [63:0] wdataReg;
  logic        isReadReg;
  logic [63:0] asmReg;
  logic [63:0] valMReg;
  logic [2:0]  statReg;

  logic [7:0]  ram [MEM_BYTES];
  logic [7:0]  rdByteReg;
  logic [AW-1:0] rdIdx;
  logic [AW-1:0] wrIdx;

  logic        isWriteOp;
  logic        isReadOp;
  logic [63:0] reqAddr;
  logic [63:0] writeData;
  logic        addrErr;
  logic [2:0]  reqStat;
  logic        reqAccess;

  // Request decode; addrErr compares against MEM_BYTES-8 so huge addresses cannot wrap.
  always_comb begin
    isWriteOp = 1'b0;
    isReadOp  = 1'b0;
    reqAddr   = bus.valE;
    writeData = bus.valA;
    case (bus.icode)
      4'd4, 4'd10: isWriteOp = 1'b1;
      4'd8: begin
        isWriteOp = 1'b1;
        writeData = bus.valP;
      end
      4'd5: isReadOp = 1'b1;
      4'd9, 4'd11: begin
        isReadOp = 1'b1;
        reqAddr  = bus.valA;
      end
      default: ;
    endcase

    addrErr   = reqAddr > MAX_ADDR;
    reqStat   = AOK;
    reqAccess = 1'b0;
    if (bus.stat_in != AOK)
      reqStat = bus.stat_in;
    else if (bus.icode == 4'd0)
      reqStat = HLT;
    else if ((isWriteOp || isReadOp) && addrErr)
      reqStat = ADR;
    else
      reqAccess = isWriteOp || isReadOp;
  end

  // Read address runs one byte ahead so the registered RAM output holds byte cnt at edge cnt.
  assign wrIdx = AW'(addrReg + 64'(cntReg));
  assign rdIdx = (stateReg == ACCESS) ? AW'(addrReg + 64'(cntReg) + 64'd1) : AW'(reqAddr);

  always_ff @(posedge clk) begin
    if (stateReg == ACCESS && !isReadReg)
      ram[wrIdx] <= wdataReg[{cntReg, 3'b000} +: 8];
    rdByteReg <= ram[rdIdx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      cntReg    <= 3'd0;
      addrReg   <= 64'd0;
      wdataReg  <= 64'd0;
      isReadReg <= 1'b0;
      asmReg    <= 64'd0;
      valMReg   <= 64'd0;
      statReg   <= AOK;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            addrReg   <= reqAddr;
            wdataReg  <= writeData;
            isReadReg <= isReadOp;
            cntReg    <= 3'd0;
            if (reqAccess) begin
              stateReg <= ACCESS;
            end else begin
              statReg  <= reqStat;
              valMReg  <= 64'd0;
              stateReg <= DONE;
            end
          end
        end
        ACCESS: begin
          if (isReadReg)
            asmReg <= {rdByteReg, asmReg[63:8]};
          cntReg <= cntReg + 3'd1;
          if (cntReg == 3'd7) begin
            statReg  <= AOK;
            valMReg  <= isReadReg ? {rdByteReg, asmReg[63:8]} : 64'd0;
            stateReg <= DONE;
          end
        end
        DONE:    stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.busy = (stateReg != IDLE);
  assign bus.done = (stateReg == DONE);
  assign bus.valM = valMReg;
  assign bus.stat = statReg;
endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against a byte-array model
// of the data RAM and the status/latency rules of the stage.
module tb_memory_stage;
  localparam int MEM = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  memory_stage_if bus();

  memory_stage #(.MEM_BYTES(MEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [MEM];
  bit         known [MEM];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction: model prediction, drive, bounded wait for done, compare.
  task automatic runOp(input string tag, input logic [3:0] ic, input logic [63:0] a,
                       input logic [63:0] e, input logic [63:0] p, input logic [2:0] si);
    logic        isWr, isRd;
    logic [63:0] addr, wdata, expValM;
    logic [2:0]  expStat;
    int          expLat, lat;
    isWr    = (ic == 4'd4) || (ic == 4'd10) || (ic == 4'd8);
    isRd    = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
    addr    = (ic == 4'd9 || ic == 4'd11) ? a : e;
    wdata   = (ic == 4'd8) ? p : a;
    expValM = 64'd0;
    expLat  = 1;
    if (si != 3'd1)                              expStat = si;
    else if (ic == 4'd0)                         expStat = 3'd2;
    else if ((isWr || isRd) && addr > MEM - 8)   expStat = 3'd3;
    else begin
      expStat = 3'd1;
      if (isWr || isRd) expLat = 9;
      for (int k = 0; k < 8; k++) begin
        if (isWr) begin
          model[int'(addr) + k] = wdata[8*k +: 8];
          known[int'(addr) + k] = 1'b1;
        end
        if (isRd) expValM = expValM | (64'(model[int'(addr) + k]) << (8 * k));
      end
    end

    @(negedge clk);
    bus.icode = ic; bus.valA = a; bus.valE = e; bus.valP = p; bus.stat_in = si;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.icode   = 4'($urandom);
    bus.valA    = {$urandom, $urandom};
    bus.valE    = {$urandom, $urandom};
    bus.valP    = {$urandom, $urandom};
    bus.stat_in = 3'($urandom);
    check({tag, " busy"}, 64'(bus.busy), 64'd1);
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(expLat));
    check({tag, " stat"}, 64'(bus.stat), 64'(expStat));
    check({tag, " valM"}, bus.valM, expValM);
    $display("op %s icode=%0d addr=0x%0h stat=%0d valM=0x%0h latency=%0d",
             tag, ic, addr, bus.stat, bus.valM, lat);
    @(negedge clk);
    check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    check({tag, " idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic zeroFill(input logic [63:0] addr);
    runOp("zero", 4'd4, 64'd0, addr, 64'd0, 3'd1);
  endtask

  initial begin
    logic [63:0] addr, data, a, e;
    logic [3:0]  ic;
    logic [2:0]  si;
    int          pulses, badBytes;
    logic [63:0] seenValM;
    logic [3:0]  icList [12];

    icList = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd2, 4'd3, 4'd6, 4'd7};
    for (int i = 0; i < MEM; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b0;
    end
    bus.start = 1'b0; bus.icode = 4'd1; bus.valA = 64'd0; bus.valE = 64'd0;
    bus.valP = 64'd0; bus.stat_in = 3'd1;

    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset valM", bus.valM, 64'd0);
    check("reset stat", 64'(bus.stat), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset stat", 64'(bus.stat), 64'd1);

    // Give every byte the bench later reads a defined value.
    zeroFill(64'h10); zeroFill(64'h40); zeroFill(64'h200); zeroFill(64'd1008); zeroFill(64'd1016);
    for (int k = 0; k < 16; k++) zeroFill(64'h100 + 64'(8 * k));

    runOp("rmmovq", 4'd4, 64'h1122334455667788, 64'h10, 64'd0, 3'd1);
    check("ram 0x10", 64'(dut.ram[16'h10]), 64'h88);
    check("ram 0x17", 64'(dut.ram[16'h17]), 64'h11);
    runOp("mrmovq", 4'd5, 64'd0, 64'h10, 64'd0, 3'd1);
    runOp("bound 1016", 4'd5, 64'd0, 64'd1016, 64'd0, 3'd1);
    runOp("bound 1017", 4'd5, 64'd0, 64'd1017, 64'd0, 3'd1);
    runOp("bound wrap", 4'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 3'd1);
    runOp("wr 1017", 4'd4, 64'hDEAD_BEEF_0000_0001, 64'd1017, 64'd0, 3'd1);
    runOp("call", 4'd8, 64'd0, 64'h200, 64'h42, 3'd1);
    runOp("ret", 4'd9, 64'h200, 64'd0, 64'd0, 3'd1);
    runOp("popq", 4'd11, 64'h200, 64'd0, 64'd0, 3'd1);
    runOp("pass ins", 4'd4, 64'hABCD, 64'h10, 64'd0, 3'd4);
    runOp("halt", 4'd0, 64'd0, 64'd0, 64'd0, 3'd1);
    runOp("nop", 4'd1, 64'd0, 64'd0, 64'd0, 3'd1);
    runOp("reread", 4'd5, 64'd0, 64'h10, 64'd0, 3'd1);

    // Reset four edges into a pushq: only bytes 0..2 land.
    @(negedge clk);
    bus.icode = 4'd10; bus.valA = 64'hFFFF_FFFF_FFFF_FFFF; bus.valE = 64'h40; bus.stat_in = 3'd1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) model[16'h40 + k] = 8'hFF;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst stat", 64'(bus.stat), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) check($sformatf("ram 0x%0h", 16'h40 + k),
                                      64'(dut.ram[16'h40 + k]), 64'(model[16'h40 + k]));
    $display("op reset-mid-pushq busy=%0d done=%0d stat=%0d", bus.busy, bus.done, bus.stat);

    // start re-asserted during ACCESS must be ignored.
    @(negedge clk);
    bus.icode = 4'd5; bus.valE = 64'h10; bus.stat_in = 3'd1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.icode = 4'd0; bus.valE = 64'h48;
    pulses = 0;
    seenValM = 64'd0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        seenValM = bus.valM;
      end
      @(negedge clk);
    end
    check("busy-start pulses", 64'(pulses), 64'd1);
    check("busy-start valM", seenValM, 64'h1122334455667788);
    check("busy-start stat", 64'(bus.stat), 64'd1);
    $display("op busy-start pulses=%0d valM=0x%0h", pulses, seenValM);

    for (int n = 0; n < 40; n++) begin
      ic = icList[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0, 1:    addr = 64'h100 + 64'($urandom_range(0, 120));
        2:       addr = 64'($urandom_range(1008, 1023));
        default: addr = {32'hFFFF_FFFF, $urandom};
      endcase
      data = {$urandom, $urandom};
      si   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      if (ic == 4'd9 || ic == 4'd11) begin
        a = addr;
        e = {$urandom, $urandom};
      end else begin
        a = data;
        e = addr;
      end
      runOp($sformatf("rand%0d", n), ic, a, e, {$urandom, $urandom}, si);
    end

    badBytes = 0;
    for (int i = 0; i < MEM; i++)
      if (known[i] && dut.ram[i] !== model[i]) badBytes++;
    check("ram image", 64'(badBytes), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
